// File: rtl/state_dump_if.sv
// Dump stream interface: one word per valid/ready handshake, tagged with
// its source (register file or data memory) and its index in that source.
interface state_dump_if #(
    parameter int DATA_W = 32
);
    logic              dump_valid_o;
    logic              dump_ready_i;
    logic [DATA_W-1:0] dump_data_o;
    logic              dump_tag_o;
    logic [4:0]        dump_idx_o;

    // Producer side (the dump engine)
    modport master (
        output dump_valid_o,
        output dump_data_o,
        output dump_tag_o,
        output dump_idx_o,
        input  dump_ready_i
    );

    // Consumer side
    modport slave (
        input  dump_valid_o,
        input  dump_data_o,
        input  dump_tag_o,
        input  dump_idx_o,
        output dump_ready_i
    );
endinterface

// File: rtl/state_dump.sv
// State dump engine: lets the CPU run for RUN_CYCLES cycles, then halts it
// and streams out the 32 register-file words followed by the first 32
// data-memory words over a valid/ready interface. Terminal once finished.
module state_dump #(
    parameter int RUN_CYCLES = 650,
    parameter int DATA_W     = 32
) (
    input  logic              clk_i,
    input  logic              rst_n,
    output logic              cpu_halt_o,
    output logic [4:0]        rf_addr_o,
    input  logic [DATA_W-1:0] rf_data_i,
    output logic [31:0]       dm_addr_o,
    input  logic [DATA_W-1:0] dm_data_i,
    output logic              done_o,
    state_dump_if.master      dump
);

    typedef enum logic [1:0] {
        ST_RUN   = 2'd0,
        ST_FETCH = 2'd1,
        ST_SEND  = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    // Counter value on the last run cycle
    localparam logic [15:0] RUN_LAST = 16'(RUN_CYCLES - 1);

    state_t            state_r,    state_next_s;
    logic [15:0]       cnt_r,      cnt_next_s;
    logic              phase_r,    phase_next_s;
    logic [4:0]        idx_r,      idx_next_s;
    logic [DATA_W-1:0] data_r,     data_next_s;
    logic              tag_r,      tag_next_s;
    logic [4:0]        widx_r,     widx_next_s;
    logic              halt_r;
    logic              valid_r;
    logic              done_r;

    // Next-state and datapath decode; every register holds unless updated
    always_comb begin
        state_next_s = state_r;
        cnt_next_s   = cnt_r;
        phase_next_s = phase_r;
        idx_next_s   = idx_r;
        data_next_s  = data_r;
        tag_next_s   = tag_r;
        widx_next_s  = widx_r;

        case (state_r)
            ST_RUN: begin
                // Saturate rather than wrap; only reachable for the largest count
                if (cnt_r != 16'hFFFF) begin
                    cnt_next_s = cnt_r + 16'd1;
                end else begin
                    cnt_next_s = cnt_r;
                end
                if (cnt_r == RUN_LAST) begin
                    state_next_s = ST_FETCH;
                    phase_next_s = 1'b0;
                    idx_next_s   = 5'd0;
                end else begin
                    state_next_s = ST_RUN;
                end
            end
            ST_FETCH: begin
                // Read data arrives combinationally from the address driven by idx
                if (phase_r) begin
                    data_next_s = dm_data_i;
                end else begin
                    data_next_s = rf_data_i;
                end
                tag_next_s   = phase_r;
                widx_next_s  = idx_r;
                state_next_s = ST_SEND;
            end
            ST_SEND: begin
                if (dump.dump_ready_i) begin
                    if (idx_r != 5'd31) begin
                        idx_next_s   = idx_r + 5'd1;
                        state_next_s = ST_FETCH;
                    end else if (!phase_r) begin
                        phase_next_s = 1'b1;
                        idx_next_s   = 5'd0;
                        state_next_s = ST_FETCH;
                    end else begin
                        state_next_s = ST_DONE;
                    end
                end else begin
                    state_next_s = ST_SEND;
                end
            end
            ST_DONE: begin
                state_next_s = ST_DONE;
            end
            default: begin
                state_next_s = ST_RUN;
            end
        endcase
    end

    // State register with synchronous reset; outputs decoded from next state
    always_ff @(posedge clk_i) begin
        if (!rst_n) begin
            state_r <= ST_RUN;
            cnt_r   <= 16'd0;
            phase_r <= 1'b0;
            idx_r   <= 5'd0;
            data_r  <= '0;
            tag_r   <= 1'b0;
            widx_r  <= 5'd0;
            halt_r  <= 1'b0;
            valid_r <= 1'b0;
            done_r  <= 1'b0;
        end else begin
            state_r <= state_next_s;
            cnt_r   <= cnt_next_s;
            phase_r <= phase_next_s;
            idx_r   <= idx_next_s;
            data_r  <= data_next_s;
            tag_r   <= tag_next_s;
            widx_r  <= widx_next_s;
            halt_r  <= (state_next_s != ST_RUN);
            valid_r <= (state_next_s == ST_SEND);
            done_r  <= (state_next_s == ST_DONE);
        end
    end

    assign cpu_halt_o        = halt_r;
    assign done_o            = done_r;
    assign rf_addr_o         = idx_r;
    assign dm_addr_o         = {25'd0, idx_r, 2'b00};
    assign dump.dump_valid_o = valid_r;
    assign dump.dump_data_o  = data_r;
    assign dump.dump_tag_o   = tag_r;
    assign dump.dump_idx_o   = widx_r;

endmodule

// File: tb/tb_state_dump.sv
// Directed bench for state_dump: reset values, run-length count, full ordered
// dump with a stall and the RF/DM boundary, terminal DONE, mid-dump reset and
// a dump under random back-pressure. A second instance uses RUN_CYCLES=1.
module tb_state_dump;
    localparam int DATA_W     = 32;
    localparam int RUN_CYCLES = 650;

    logic              clk_i = 1'b0;
    logic              rst_n;
    logic              cpu_halt_o, done_o;
    logic [4:0]        rf_addr_o;
    logic [31:0]       dm_addr_o;
    logic [DATA_W-1:0] rf_data_i, dm_data_i;

    logic              cpu_halt2, done2;
    logic [4:0]        rf_addr2;
    logic [31:0]       dm_addr2;
    logic [DATA_W-1:0] rf_data2, dm_data2;

    logic [DATA_W-1:0] rf_mem [32];
    logic [DATA_W-1:0] dm_mem [32];

    int checks = 0;
    int errors = 0;

    state_dump_if #(.DATA_W(DATA_W)) dif ();
    state_dump_if #(.DATA_W(DATA_W)) dif2 ();

    always #5 clk_i = ~clk_i;

    assign rf_data_i = rf_mem[rf_addr_o];
    assign dm_data_i = dm_mem[dm_addr_o[6:2]];
    assign rf_data2  = rf_mem[rf_addr2];
    assign dm_data2  = dm_mem[dm_addr2[6:2]];

    state_dump #(.RUN_CYCLES(RUN_CYCLES), .DATA_W(DATA_W)) dut (
        .clk_i      (clk_i),
        .rst_n      (rst_n),
        .cpu_halt_o (cpu_halt_o),
        .rf_addr_o  (rf_addr_o),
        .rf_data_i  (rf_data_i),
        .dm_addr_o  (dm_addr_o),
        .dm_data_i  (dm_data_i),
        .done_o     (done_o),
        .dump       (dif)
    );

    state_dump #(.RUN_CYCLES(1), .DATA_W(DATA_W)) dut_one (
        .clk_i      (clk_i),
        .rst_n      (rst_n),
        .cpu_halt_o (cpu_halt2),
        .rf_addr_o  (rf_addr2),
        .rf_data_i  (rf_data2),
        .dm_addr_o  (dm_addr2),
        .dm_data_i  (dm_data2),
        .done_o     (done2),
        .dump       (dif2)
    );

    task automatic test_reset();
        rst_n = 1'b0;
        dif.dump_ready_i  = 1'b0;
        dif2.dump_ready_i = 1'b0;
        repeat (3) @(negedge clk_i);
        checks++;
        if ({cpu_halt_o, dif.dump_valid_o, done_o, dif.dump_tag_o} !== 4'b0000) begin
            errors++;
            $display("FAIL reset_flags halt/valid/done/tag=%b expected 0000",
                     {cpu_halt_o, dif.dump_valid_o, done_o, dif.dump_tag_o});
        end
        checks++;
        if (dif.dump_data_o !== 32'd0 || dif.dump_idx_o !== 5'd0) begin
            errors++;
            $display("FAIL reset_word data=%h idx=%0d expected 0/0", dif.dump_data_o, dif.dump_idx_o);
        end
        checks++;
        if (rf_addr_o !== 5'd0 || dm_addr_o !== 32'd0) begin
            errors++;
            $display("FAIL reset_addr rf=%0d dm=%h expected 0/0", rf_addr_o, dm_addr_o);
        end
        checks++;
        if (cpu_halt2 !== 1'b0 || dif2.dump_valid_o !== 1'b0 || done2 !== 1'b0) begin
            errors++;
            $display("FAIL reset_one halt=%b valid=%b done=%b expected 0/0/0",
                     cpu_halt2, dif2.dump_valid_o, done2);
        end
    endtask

    // Counts negedges from reset release until cpu_halt_o rises (bounded)
    task automatic wait_halt(output int cyc);
        cyc = 0;
        while (cpu_halt_o !== 1'b1 && cyc < 2000) begin
            @(negedge clk_i);
            cyc++;
        end
    endtask

    task automatic test_run_count();
        int cyc;
        rst_n = 1'b1;
        cyc = 0;
        while (cpu_halt_o !== 1'b1 && cyc < 2000) begin
            @(negedge clk_i);
            cyc++;
            if (cyc == 1) begin
                checks++;
                if (cpu_halt2 !== 1'b1 || dif2.dump_valid_o !== 1'b0 || dm_addr2 !== 32'd0) begin
                    errors++;
                    $display("FAIL one_cycle_fetch halt=%b valid=%b dm_addr=%h expected 1/0/0",
                             cpu_halt2, dif2.dump_valid_o, dm_addr2);
                end
            end
            if (cyc == 2) begin
                checks++;
                if (dif2.dump_valid_o !== 1'b1 || dif2.dump_data_o !== 32'd100 ||
                    dif2.dump_tag_o !== 1'b0 || dif2.dump_idx_o !== 5'd0) begin
                    errors++;
                    $display("FAIL one_cycle_word valid=%b data=%0d tag=%b idx=%0d expected 1/100/0/0",
                             dif2.dump_valid_o, dif2.dump_data_o, dif2.dump_tag_o, dif2.dump_idx_o);
                end
            end
        end
        checks++;
        if (cyc !== 650) begin
            errors++;
            $display("FAIL halt_rise cycles=%0d expected 650", cyc);
        end
        @(negedge clk_i);
        checks++;
        if (dif.dump_valid_o !== 1'b1 || dif.dump_tag_o !== 1'b0 || dif.dump_idx_o !== 5'd0 ||
            dif.dump_data_o !== 32'd100 || cpu_halt_o !== 1'b1) begin
            errors++;
            $display("FAIL first_word valid=%b tag=%b idx=%0d data=%0d halt=%b expected 1/0/0/100/1",
                     dif.dump_valid_o, dif.dump_tag_o, dif.dump_idx_o, dif.dump_data_o, cpu_halt_o);
        end
    endtask

    task automatic test_full_dump();
        int n, cyc, k;
        logic [31:0] fetch_dm, exp_data;
        logic exp_tag, stalled;
        n = 0; cyc = 0; stalled = 1'b0; fetch_dm = 32'hFFFF_FFFF;
        dif.dump_ready_i = 1'b1;
        while (n < 64 && cyc < 1000) begin
            if (dif.dump_valid_o === 1'b1) begin
                k = n % 32;
                exp_tag  = (n >= 32);
                exp_data = exp_tag ? 32'(k * 3) : 32'(k + 100);
                checks++;
                if (dif.dump_tag_o !== exp_tag || dif.dump_idx_o !== 5'(k) || dif.dump_data_o !== exp_data) begin
                    errors++;
                    $display("FAIL order word=%0d tag=%b idx=%0d data=%0d expected %b/%0d/%0d",
                             n, dif.dump_tag_o, dif.dump_idx_o, dif.dump_data_o, exp_tag, k, exp_data);
                end
                if (exp_tag && (k == 0 || k == 5)) begin
                    checks++;
                    if (fetch_dm !== {25'd0, 5'(k), 2'b00}) begin
                        errors++;
                        $display("FAIL dm_fetch_addr word=DM[%0d] dm_addr=%h expected %h",
                                 k, fetch_dm, {25'd0, 5'(k), 2'b00});
                    end
                end
                if (n == 7 && !stalled) begin
                    dif.dump_ready_i = 1'b0;
                    for (int s = 0; s < 5; s++) begin
                        @(negedge clk_i);
                        cyc++;
                        checks++;
                        if (dif.dump_valid_o !== 1'b1 || dif.dump_data_o !== 32'd107 ||
                            dif.dump_tag_o !== 1'b0 || dif.dump_idx_o !== 5'd7) begin
                            errors++;
                            $display("FAIL stall_hold cycle=%0d valid=%b data=%0d tag=%b idx=%0d expected 1/107/0/7",
                                     s, dif.dump_valid_o, dif.dump_data_o, dif.dump_tag_o, dif.dump_idx_o);
                        end
                    end
                    dif.dump_ready_i = 1'b1;
                    stalled = 1'b1;
                end
                n++;
                fetch_dm = 32'hFFFF_FFFF;
            end else if (done_o !== 1'b1) begin
                fetch_dm = dm_addr_o;
            end
            @(negedge clk_i);
            cyc++;
        end
        checks++;
        if (n !== 64) begin
            errors++;
            $display("FAIL full_dump_count words=%0d expected 64", n);
        end
        @(negedge clk_i);
        checks++;
        if (done_o !== 1'b1 || dif.dump_valid_o !== 1'b0 || cpu_halt_o !== 1'b1) begin
            errors++;
            $display("FAIL done_rise done=%b valid=%b halt=%b expected 1/0/1",
                     done_o, dif.dump_valid_o, cpu_halt_o);
        end
    endtask

    task automatic test_done_terminal();
        for (int i = 0; i < 10; i++) begin
            dif.dump_ready_i = (i % 2 == 0);
            @(negedge clk_i);
            checks++;
            if (done_o !== 1'b1 || dif.dump_valid_o !== 1'b0 || cpu_halt_o !== 1'b1) begin
                errors++;
                $display("FAIL done_terminal cycle=%0d done=%b valid=%b halt=%b expected 1/0/1",
                         i, done_o, dif.dump_valid_o, cpu_halt_o);
            end
        end
    endtask

    task automatic test_reset_mid_dump();
        int cyc;
        bit found;
        rst_n = 1'b0;
        dif.dump_ready_i = 1'b0;
        @(negedge clk_i);
        rst_n = 1'b1;
        wait_halt(cyc);
        dif.dump_ready_i = 1'b1;
        found = 1'b0;
        cyc = 0;
        while (!found && cyc < 1000) begin
            @(negedge clk_i);
            cyc++;
            if (dif.dump_valid_o === 1'b1 && dif.dump_tag_o === 1'b1 && dif.dump_idx_o === 5'd10)
                found = 1'b1;
        end
        checks++;
        if (!found || dif.dump_data_o !== 32'd30) begin
            errors++;
            $display("FAIL reach_dm10 found=%0d data=%0d expected 1/30", found, dif.dump_data_o);
        end
        rst_n = 1'b0;
        dif.dump_ready_i = 1'b0;
        @(negedge clk_i);
        checks++;
        if (dif.dump_valid_o !== 1'b0 || cpu_halt_o !== 1'b0 || done_o !== 1'b0 || dif.dump_data_o !== 32'd0) begin
            errors++;
            $display("FAIL mid_reset valid=%b halt=%b done=%b data=%0d expected 0/0/0/0",
                     dif.dump_valid_o, cpu_halt_o, done_o, dif.dump_data_o);
        end
        rst_n = 1'b1;
        wait_halt(cyc);
        checks++;
        if (cyc !== 650) begin
            errors++;
            $display("FAIL rerun_count cycles=%0d expected 650", cyc);
        end
    endtask

    task automatic test_random_ready();
        int n, cyc, k;
        logic [31:0] exp_data, held_data;
        logic exp_tag, held_tag, pending;
        logic [4:0] held_idx;
        n = 0; cyc = 0; pending = 1'b0;
        held_data = '0; held_tag = 1'b0; held_idx = '0;
        while (n < 64 && cyc < 3000) begin
            dif.dump_ready_i = 1'($urandom_range(0, 1));
            if (pending) begin
                checks++;
                if (dif.dump_valid_o !== 1'b1 || dif.dump_data_o !== held_data ||
                    dif.dump_tag_o !== held_tag || dif.dump_idx_o !== held_idx) begin
                    errors++;
                    $display("FAIL rand_hold word=%0d valid=%b data=%0d tag=%b idx=%0d expected 1/%0d/%b/%0d",
                             n, dif.dump_valid_o, dif.dump_data_o, dif.dump_tag_o, dif.dump_idx_o,
                             held_data, held_tag, held_idx);
                end
            end
            if (dif.dump_valid_o === 1'b1) begin
                if (dif.dump_ready_i) begin
                    k = n % 32;
                    exp_tag  = (n >= 32);
                    exp_data = exp_tag ? 32'(k * 3) : 32'(k + 100);
                    checks++;
                    if (dif.dump_tag_o !== exp_tag || dif.dump_idx_o !== 5'(k) || dif.dump_data_o !== exp_data) begin
                        errors++;
                        $display("FAIL rand_order word=%0d tag=%b idx=%0d data=%0d expected %b/%0d/%0d",
                                 n, dif.dump_tag_o, dif.dump_idx_o, dif.dump_data_o, exp_tag, k, exp_data);
                    end
                    n++;
                    pending = 1'b0;
                end else begin
                    pending   = 1'b1;
                    held_data = dif.dump_data_o;
                    held_tag  = dif.dump_tag_o;
                    held_idx  = dif.dump_idx_o;
                end
            end
            @(negedge clk_i);
            cyc++;
        end
        checks++;
        if (n !== 64) begin
            errors++;
            $display("FAIL rand_count words=%0d expected 64", n);
        end
        for (int i = 0; i < 20; i++) begin
            dif.dump_ready_i = 1'($urandom_range(0, 1));
            @(negedge clk_i);
            checks++;
            if (done_o !== 1'b1 || dif.dump_valid_o !== 1'b0) begin
                errors++;
                $display("FAIL rand_done cycle=%0d done=%b valid=%b expected 1/0", i, done_o, dif.dump_valid_o);
            end
        end
    endtask

    initial begin
        for (int i = 0; i < 32; i++) begin
            rf_mem[i] = 32'(i + 100);
            dm_mem[i] = 32'(i * 3);
        end
        test_reset();
        test_run_count();
        test_full_dump();
        test_done_terminal();
        test_reset_mid_dump();
        test_random_ready();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/state_dump.md
STATE_DUMP -- requirements
Module: state_dump

Interface
REQ-001 SHALL have parameter RUN_CYCLES, default 650, meaning the number of CPU run cycles before the dump starts (legal range 1..65535).
REQ-002 SHALL have parameter DATA_W, default 32, meaning the register, memory and dump word width.
REQ-003 SHALL have port clk_i  input  1  single clock; all state changes on its rising edge.
REQ-004 SHALL have port rst_n  input  1  reset, synchronous and active-low.
REQ-005 SHALL have port cpu_halt_o  output  1  freezes the CPU (PC and pipeline registers hold) while high.
REQ-006 SHALL have port rf_addr_o  output  5  register-file read address.
REQ-007 SHALL have port rf_data_i  input  DATA_W  register-file read data, combinational from rf_addr_o.
REQ-008 SHALL have port dm_addr_o  output  32  data-memory byte address, always {25'b0, idx, 2'b00}.
REQ-009 SHALL have port dm_data_i  input  DATA_W  data-memory read data, combinational from dm_addr_o.
REQ-010 SHALL have port dump_valid_o  output  1  dump word available.
REQ-011 SHALL have port dump_ready_i  input  1  consumer accepts the dump word.
REQ-012 SHALL have port dump_data_o  output  DATA_W  dump word.
REQ-013 SHALL have port dump_tag_o  output  1  source of the word: 0 = register file, 1 = data memory.
REQ-014 SHALL have port dump_idx_o  output  5  register number or memory word index of the word.
REQ-015 SHALL have port done_o  output  1  all 64 words delivered.

Function
REQ-016 SHALL implement FSM states RUN, FETCH, SEND and DONE, plus a 1-bit phase (0 = RF, 1 = DM) and a 5-bit index idx.
REQ-017 In RUN, a 16-bit cycle counter SHALL increment every cycle; when the counter equals RUN_CYCLES-1, the next state SHALL be FETCH with phase=0 and idx=0.
REQ-018 The counter SHALL hold its value outside RUN and SHALL never wrap.
REQ-019 cpu_halt_o SHALL be registered: 0 in RUN, and 1 in FETCH, SEND and DONE.
REQ-020 rf_addr_o SHALL equal idx in every state.
REQ-021 The dm_addr_o index field SHALL equal idx in every state.
REQ-022 In FETCH, the block SHALL capture rf_data_i (phase 0) or dm_data_i (phase 1) into dump_data_o.
REQ-023 In FETCH, the block SHALL load dump_tag_o with phase and dump_idx_o with idx, then move to SEND; read latency is 1 cycle.
REQ-024 dump_valid_o SHALL be high exactly while in SEND.
REQ-025 While dump_valid_o=1 and dump_ready_i=0, dump_data_o, dump_tag_o and dump_idx_o SHALL hold stable.
REQ-026 A word SHALL be accepted on a cycle with dump_valid_o=1 and dump_ready_i=1.
REQ-027 On acceptance with idx<31, the block SHALL increment idx and return to FETCH.
REQ-028 On acceptance with idx=31 and phase=0, the block SHALL set phase=1 and idx=0 and return to FETCH.
REQ-029 On acceptance with idx=31 and phase=1, the block SHALL go to DONE.
REQ-030 Peak throughput SHALL be one word per 2 cycles; order SHALL be RF[0..31] then DM[0..31]; exactly 64 words SHALL be delivered.
REQ-031 dump_ready_i high before SEND SHALL have no effect; no word is skipped or repeated.
REQ-032 DONE SHALL be terminal until reset: done_o=1, dump_valid_o=0, cpu_halt_o=1, and dump_ready_i is ignored.
REQ-033 If RUN_CYCLES=1, FETCH SHALL be entered on the first cycle after reset release.

Reset
REQ-034 When rst_n=0 at a rising edge, the next state SHALL be RUN with counter=0, phase=0 and idx=0.
REQ-035 Reset SHALL force cpu_halt_o=0, dump_valid_o=0, done_o=0, dump_data_o=0, dump_tag_o=0 and dump_idx_o=0.
REQ-036 Reset asserted mid-dump SHALL abort the dump; after release the block SHALL rerun the full RUN_CYCLES count and restart at RF[0].

Verification
REQ-037 Scenario (RUN_CYCLES=650, dump_ready_i=1): release reset -> cpu_halt_o rises after exactly 650 cycles; first word is tag 0, idx 0, value = RF[0].
REQ-038 Scenario (RF[i]=i+100, DM[i]=i*3, dump_ready_i=1): -> 64 words in order; RF[31] is 131; DM[31] is 93; done_o rises 1 cycle after the last acceptance.
REQ-039 Scenario (dump_ready_i held low for 5 cycles on RF[7]): -> dump_valid_o stays 1 and data/tag/idx stay unchanged (value 107) throughout; the next word after release is RF[8].
REQ-040 Scenario (RF-to-DM boundary): -> the word after RF[31] is tag 1, idx 0, with dm_addr_o=0x00000000 during its FETCH; the DM[5] FETCH shows dm_addr_o=0x00000014.
REQ-041 Scenario (rst_n pulsed low during SEND of DM[10]): -> the next cycle shows dump_valid_o=0 and cpu_halt_o=0; a full 64-word dump repeats after 650 more cycles.
REQ-042 Scenario (randomized dump_ready_i, 50% duty): -> exactly 64 accepted words, no duplicates or gaps, and done_o stays 1 thereafter.
